mole_round_ctrl: RTL and testbench
==================================

MOLE_ROUND_CTRL -- requirements
Module: mole_round_ctrl

Interface
REQ-001 SHALL have parameter WINDOW_CYCLES, default 50000000, meaning the number of clock cycles a mole stays lit (reaction window).
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000, meaning the number of all-dark cycles between rounds.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5, meaning the non-zero reset value of the mole-select LFSR.
REQ-004 SHALL have port systemClock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port enable, input, 1 bit: game-running level from the game-state FSM.
REQ-007 SHALL have port keys, input, 4 bits: raw active-high pushbuttons, one per mole, asynchronous to systemClock.
REQ-008 SHALL have port mole, output, 4 bits: one-hot lit-mole drive, or all zero when no mole is lit.
REQ-009 SHALL have port W, output, 1 bit: round result, 1 = hit and 0 = miss; held between resolutions.
REQ-010 SHALL have port timeUp, output, 1 bit: round-end strobe whose falling edge tells the score counter to sample W.

Function
REQ-011 SHALL pass each keys bit through a 2-flop synchronizer and then a rising-edge detector, so a press first becomes visible as a 1-cycle key event 3 cycles after the raw rise.
REQ-012 SHALL implement states IDLE, ARM, SHOW, RESOLVE and GAP.
REQ-013 SHALL, in IDLE, hold mole=0 and timeUp=0, and go to ARM on the first cycle enable=1.
REQ-014 SHALL advance an 8-bit Fibonacci LFSR (polynomial x^8+x^6+x^5+x^4+1) every clock cycle in all states; the LFSR never holds 0.
REQ-015 SHALL, in ARM (1 cycle), take idx = lfsr[1:0]; if idx equals the previous round's index, use idx+1 mod 4; store the result as the previous index; load the window counter; then go to SHOW.
REQ-016 SHALL, in SHOW, drive mole = one-hot(idx) and decrement the window counter once per cycle.
REQ-017 SHALL, in SHOW, treat a key event on bit idx with no other key event in the same cycle as a hit: register W=1 and go to RESOLVE on the next cycle.
REQ-018 SHALL, in SHOW, treat any key event on a bit other than idx as a miss, including when it coincides with a correct event: register W=0 and go to RESOLVE.
REQ-019 SHALL, in SHOW, register W=0 and go to RESOLVE when the window counter reaches 0 with no key event.
REQ-020 SHALL treat a correct key event in the same cycle the window counter reaches 0 as a hit.
REQ-021 SHALL, in RESOLVE, drive mole=0, hold W constant, and drive timeUp=1 for exactly 2 cycles, with the first such cycle one cycle after W was registered, so W is stable 2 cycles before and at the timeUp falling edge.
REQ-022 SHALL, after RESOLVE, enter GAP with mole=0 and timeUp=0, count GAP_CYCLES cycles ignoring all key events, then go to ARM.
REQ-023 SHALL, whenever enable=0 in any state other than IDLE, go to IDLE on the next edge with mole=0 and timeUp=0, leaving W unchanged.
REQ-024 SHALL size the window and gap counters at 32 bits and never wrap them below 0.

Reset
REQ-025 SHALL, while resetn=0, immediately force state=IDLE, mole=0, W=0, timeUp=0, LFSR=LFSR_SEED, previous index=0, synchronizers and edge registers=0, and window length=WINDOW_CYCLES, with no clock required.
REQ-026 SHALL treat reset asserted mid-round as aborting the round with no timeUp pulse; the first transition after release occurs on a clock edge.

Configuration
REQ-027 SHALL, when macro MOLE_SPEEDUP_EN is defined, reduce the loaded window length by WINDOW_CYCLES>>3 after each hit, with floor WINDOW_CYCLES>>2, and restore it to WINDOW_CYCLES after each miss.
REQ-028 SHALL, when MOLE_SPEEDUP_EN is undefined, load every window with exactly WINDOW_CYCLES and contain no window-length register.

Verification
REQ-029 SHALL cover this scenario with WINDOW_CYCLES=64 and GAP_CYCLES=8: reset, enable=1 -> ARM then SHOW with exactly one mole bit set; no keys -> W=0 after 64 SHOW cycles, then timeUp high for 2 cycles, then 8 dark cycles.
REQ-030 SHALL cover: press the lit key mid-window -> W=1 registered 4 cycles after the raw press, then timeUp 1,1,0; W stable at the timeUp fall.
REQ-031 SHALL cover: press the lit key and a wrong key in the same cycle -> W=0; wrong key alone -> W=0.
REQ-032 SHALL cover: 20 consecutive rounds -> no two successive rounds light the same mole; mole is never multi-hot.
REQ-033 SHALL cover: enable=0 during SHOW, and separately resetn=0 during RESOLVE -> mole=0 and timeUp=0 within 1 cycle (reset: immediately), with W held on disable and W=0 on reset.
REQ-034 SHALL cover, with MOLE_SPEEDUP_EN defined: 7 consecutive hits -> SHOW lengths 64,56,48,40,32,24,16, with the 7th hit committed before its window expires; a following hit -> 16 again; then a miss -> the next window is 64.

Source files
------------

// File: rtl/mole_round_ctrl_if.sv
// Bundle of the game-side signals of the mole round controller.
//   enable : game-running level from the game-state FSM
//   keys   : raw active-high pushbuttons, one per mole (asynchronous)
//   mole   : one-hot lit-mole drive, zero when dark
//   W      : round result, 1 = hit, 0 = miss, held between resolutions
//   timeUp : round-end strobe; its falling edge is where W is sampled
// master = game/board side, slave = mole_round_ctrl.
interface mole_round_ctrl_if;
  logic       enable;
  logic [3:0] keys;
  logic [3:0] mole;
  logic       W;
  logic       timeUp;

  modport master (output enable, keys, input mole, W, timeUp);
  modport slave  (input enable, keys, output mole, W, timeUp);
endinterface

// File: rtl/mole_round_ctrl.sv
// Whack-a-mole round controller: picks a mole that differs from the previous
// round, lights it for a reaction window, resolves hit/miss from synchronized
// key-press events, pulses timeUp for two cycles, then waits a dark gap.
// Ports:
//   systemClock : clock, all state on rising edge
//   resetn      : asynchronous active-low reset
//   bus         : mole_round_ctrl_if.slave (enable, keys in; mole, W, timeUp out)
// Optional feature: define MOLE_SPEEDUP_EN to shorten the window by
// WINDOW_CYCLES>>3 after each hit (floor WINDOW_CYCLES>>2), restoring it to
// WINDOW_CYCLES after each miss.
module mole_round_ctrl #(
  parameter int unsigned WINDOW_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES    = 12500000,
  parameter logic [7:0]  LFSR_SEED     = 8'hA5
) (
  input  logic               systemClock,
  input  logic               resetn,
  mole_round_ctrl_if.slave   bus
);

  localparam int unsigned CNT_W  = 32;
  localparam int unsigned KEY_W  = 4;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned LFSR_W = 8;

  localparam logic [CNT_W-1:0] WIN_FULL = CNT_W'(WINDOW_CYCLES);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES);
`ifdef MOLE_SPEEDUP_EN
  localparam logic [CNT_W-1:0] WIN_STEP  = CNT_W'(WINDOW_CYCLES >> 3);
  localparam logic [CNT_W-1:0] WIN_FLOOR = CNT_W'(WINDOW_CYCLES >> 2);
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARM     = 3'd1,
    SHOW    = 3'd2,
    RESOLVE = 3'd3,
    GAP     = 3'd4
  } state_t;

  state_t              state_q, state_n;
  logic [LFSR_W-1:0]   lfsr_q;
  logic [KEY_W-1:0]    key_s1_q, key_s2_q, key_d_q, key_evt_q;
  logic [IDX_W-1:0]    idx_q, idx_n, arm_idx_c;
  logic [CNT_W-1:0]    cnt_q, cnt_n, win_load_c;
  logic                res_q, res_n;
  logic [KEY_W-1:0]    mole_q, mole_n, lit_c;
  logic                w_q, w_n;
  logic                time_up_q, time_up_n;
  logic                hit_c, miss_c;

`ifdef MOLE_SPEEDUP_EN
  logic [CNT_W-1:0]    win_len_q, win_len_n;
`endif

  assign bus.mole   = mole_q;
  assign bus.W      = w_q;
  assign bus.timeUp = time_up_q;

  // Two-flop synchronizer plus registered rising-edge detect per key.
  always_ff @(posedge systemClock or negedge resetn) begin
    if (!resetn) begin
      key_s1_q  <= '0;
      key_s2_q  <= '0;
      key_d_q   <= '0;
      key_evt_q <= '0;
    end else begin
      key_s1_q  <= bus.keys;
      key_s2_q  <= key_s1_q;
      key_d_q   <= key_s2_q;
      key_evt_q <= key_s2_q & ~key_d_q;
    end
  end

  // Free-running Fibonacci LFSR, x^8+x^6+x^5+x^4+1; never reaches zero.
  always_ff @(posedge systemClock or negedge resetn) begin
    if (!resetn) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  // State and registered outputs.
  always_ff @(posedge systemClock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      res_q     <= 1'b0;
      mole_q    <= '0;
      w_q       <= 1'b0;
      time_up_q <= 1'b0;
`ifdef MOLE_SPEEDUP_EN
      win_len_q <= WIN_FULL;
`endif
    end else begin
      state_q   <= state_n;
      idx_q     <= idx_n;
      cnt_q     <= cnt_n;
      res_q     <= res_n;
      mole_q    <= mole_n;
      w_q       <= w_n;
      time_up_q <= time_up_n;
`ifdef MOLE_SPEEDUP_EN
      win_len_q <= win_len_n;
`endif
    end
  end

`ifdef MOLE_SPEEDUP_EN
  assign win_load_c = win_len_q;
`else
  assign win_load_c = WIN_FULL;
`endif

  // Next-state, counters and output values.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    cnt_n     = cnt_q;
    res_n     = res_q;
    w_n       = w_q;
    hit_c     = 1'b0;
    miss_c    = 1'b0;
    lit_c     = KEY_W'(1) << idx_q;
    // Re-roll a repeat by stepping to the neighbouring mole.
    arm_idx_c = lfsr_q[1:0];
    if (arm_idx_c == idx_q) begin
      arm_idx_c = arm_idx_c + IDX_W'(1);
    end

    if (!bus.enable && (state_q != IDLE)) begin
      state_n = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enable) begin
            state_n = ARM;
          end
        end
        ARM: begin
          idx_n   = arm_idx_c;
          cnt_n   = win_load_c;
          state_n = SHOW;
        end
        SHOW: begin
          // A wrong key wins over a simultaneous correct key; a correct key
          // in the final window cycle still counts as a hit.
          if ((key_evt_q & ~lit_c) != '0) begin
            miss_c = 1'b1;
          end else if (key_evt_q[idx_q]) begin
            hit_c = 1'b1;
          end else if (cnt_q <= CNT_W'(1)) begin
            miss_c = 1'b1;
            cnt_n  = '0;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
          if (hit_c || miss_c) begin
            w_n     = hit_c;
            res_n   = 1'b0;
            state_n = RESOLVE;
          end
        end
        RESOLVE: begin
          if (res_q) begin
            cnt_n   = GAP_LOAD;
            state_n = GAP;
          end else begin
            res_n = 1'b1;
          end
        end
        GAP: begin
          if (cnt_q <= CNT_W'(1)) begin
            cnt_n   = '0;
            state_n = ARM;
          end else begin
            cnt_n = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end

    mole_n    = (state_n == SHOW) ? (KEY_W'(1) << idx_n) : '0;
    // timeUp trails RESOLVE by one cycle so W is settled before it rises.
    time_up_n = (state_q == RESOLVE) && (state_n != IDLE);
  end

`ifdef MOLE_SPEEDUP_EN
  // Window length: shrink on hit down to the floor, restore on miss.
  always_comb begin
    win_len_n = win_len_q;
    if (hit_c) begin
      if (win_len_q >= (WIN_FLOOR + WIN_STEP)) begin
        win_len_n = win_len_q - WIN_STEP;
      end else begin
        win_len_n = WIN_FLOOR;
      end
    end else if (miss_c) begin
      win_len_n = WIN_FULL;
    end
  end
`endif

endmodule

// File: tb/tb_mole_round_ctrl.sv
// Self-checking bench for mole_round_ctrl (WINDOW_CYCLES=64, GAP_CYCLES=8).
// Vectors give key mode, press sample, expected W and expected lit length;
// expectations are queued when a round is driven and popped at resolution.
module tb_mole_round_ctrl;

  localparam int unsigned WIN = 64;
  localparam int unsigned GAP = 8;

  typedef struct {
    int   mode;      // 0 none, 1 correct, 2 wrong, 3 correct+wrong
    int   press_at;  // lit sample index at which keys are driven
    logic exp_w;
    int   exp_len;   // number of cycles the mole is lit
  } vec_t;

  typedef struct {
    logic w;
    int   len;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mole_round_ctrl_if bus();

  mole_round_ctrl #(
    .WINDOW_CYCLES(WIN),
    .GAP_CYCLES   (GAP),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .systemClock(clk),
    .resetn     (rst_n),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int        checks = 0;
  int        failures = 0;
  vec_t      tbl[$];
  exp_t      sb_q[$];
  logic [3:0] prev_lit;
  logic      prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] rot(input logic [3:0] v);
    return {v[2:0], v[3]};
  endfunction

  task automatic wait_lit(output logic ok);
    int n;
    n = 0;
    while (bus.mole == 4'd0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    ok = (bus.mole != 4'd0);
    if (!ok) check("lit_timeout", 32'(ok), 32'd1);
  endtask

  // One full round: light, optional press, resolution, timeUp pulse, gap.
  task automatic run_round(input vec_t v);
    logic       ok;
    logic [3:0] lit, key_v;
    int         lit_cnt, n, dark;
    exp_t       e;
    wait_lit(ok);
    if (!ok) return;
    lit = bus.mole;
    check("onehot", 32'($onehot(lit)), 32'd1);
    if (prev_valid) check("repeat_mole", 32'(lit != prev_lit), 32'd1);
    prev_lit   = lit;
    prev_valid = 1'b1;
    case (v.mode)
      1:       key_v = lit;
      2:       key_v = rot(lit);
      3:       key_v = lit | rot(lit);
      default: key_v = 4'd0;
    endcase
    e.w   = v.exp_w;
    e.len = v.exp_len;
    sb_q.push_back(e);
    lit_cnt = 1;
    n = 0;
    while (bus.mole == lit && n < 300) begin
      if (lit_cnt == v.press_at) bus.keys = key_v;
      @(negedge clk);
      if (bus.mole == lit) lit_cnt++;
      n++;
    end
    bus.keys = 4'd0;
    check("mole_off", 32'(bus.mole), 32'd0);
    e = sb_q.pop_front();
    check("W_result", 32'(bus.W), 32'(e.w));
    check("lit_len", 32'(lit_cnt), 32'(e.len));
    check("tu_lag", 32'(bus.timeUp), 32'd0);
    @(negedge clk);
    check("tu_first", 32'(bus.timeUp), 32'd1);
    @(negedge clk);
    check("tu_second", 32'(bus.timeUp), 32'd1);
    check("W_stable", 32'(bus.W), 32'(e.w));
    @(negedge clk);
    check("tu_fall", 32'(bus.timeUp), 32'd0);
    check("W_at_fall", 32'(bus.W), 32'(e.w));
    dark = 0;
    while (bus.mole == 4'd0 && bus.timeUp == 1'b0 && dark < 100) begin
      dark++;
      @(negedge clk);
    end
    check("gap_len", 32'(dark), 32'(GAP));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       ok, w_hold;
    logic [3:0] lit;
    int         n;
    vec_t       v;

    bus.enable = 1'b0;
    bus.keys   = 4'd0;

`ifdef MOLE_SPEEDUP_EN
    tbl.push_back('{1, 61, 1'b1, 64});
    tbl.push_back('{1, 53, 1'b1, 56});
    tbl.push_back('{1, 45, 1'b1, 48});
    tbl.push_back('{1, 37, 1'b1, 40});
    tbl.push_back('{1, 29, 1'b1, 32});
    tbl.push_back('{1, 21, 1'b1, 24});
    tbl.push_back('{1, 13, 1'b1, 16});
    tbl.push_back('{1, 13, 1'b1, 16});
    tbl.push_back('{0,  0, 1'b0, 16});
    tbl.push_back('{0,  0, 1'b0, 64});
`else
    tbl.push_back('{0,  0, 1'b0, 64});
    tbl.push_back('{1, 10, 1'b1, 13});
    tbl.push_back('{1, 61, 1'b1, 64});
    tbl.push_back('{1, 62, 1'b0, 64});
    tbl.push_back('{2, 20, 1'b0, 23});
    tbl.push_back('{3,  5, 1'b0,  8});
    tbl.push_back('{1,  1, 1'b1,  4});
`endif

    // Reset state with no clock edge yet.
    #1;
    check("rst_mole", 32'(bus.mole), 32'd0);
    check("rst_W", 32'(bus.W), 32'd0);
    check("rst_timeUp", 32'(bus.timeUp), 32'd0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_mole", 32'(bus.mole), 32'd0);

    bus.enable = 1'b1;
    @(negedge clk);
    check("arm_dark", 32'(bus.mole), 32'd0);
    @(negedge clk);
    check("show_latency", 32'(bus.mole != 4'd0), 32'd1);

    foreach (tbl[i]) run_round(tbl[i]);

    for (int i = 0; i < 20; i++) begin
      v = '{1, 1 + (i % 4), 1'b1, 4 + (i % 4)};
      run_round(v);
    end

    // Disable mid-SHOW: dark within one cycle, W held.
    wait_lit(ok);
    repeat (5) @(negedge clk);
    w_hold = bus.W;
    bus.enable = 1'b0;
    @(negedge clk);
    check("dis_mole", 32'(bus.mole), 32'd0);
    check("dis_timeUp", 32'(bus.timeUp), 32'd0);
    check("dis_W", 32'(bus.W), 32'(w_hold));
    repeat (3) @(negedge clk);
    check("dis_idle", 32'(bus.mole), 32'd0);
    prev_valid = 1'b0;

    // Reset during RESOLVE (timeUp high after a hit): immediate clear.
    bus.enable = 1'b1;
    wait_lit(ok);
    lit = bus.mole;
    bus.keys = lit;
    n = 0;
    while (bus.mole != 4'd0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    bus.keys = 4'd0;
    check("rr_hit_W", 32'(bus.W), 32'd1);
    @(negedge clk);
    check("rr_timeUp", 32'(bus.timeUp), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rr_mole", 32'(bus.mole), 32'd0);
    check("rr_timeUp_clr", 32'(bus.timeUp), 32'd0);
    check("rr_W", 32'(bus.W), 32'd0);
    @(negedge clk);
    check("rr_no_pulse", 32'(bus.timeUp), 32'd0);
    rst_n = 1'b1;

    run_round('{1, 2, 1'b1, 5});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
